decode_ctrl: RTL
================

Name: decode_ctrl

Overview:
Decode-stage controller for the pipelined RV32I core.
- Owns the IF/ID instruction register and decodes the opcode.
- Configures the immediate extend unit by driving its format select and instruction bits.
- Sequences the front end: one-cycle load-use stall/bubble and branch flush, with fetch-side valid/stall handshake.

Parameters:
XLEN, 32, instruction width; only 32 supported.
STALL_CNT_W, 32, width of optional stall-cycle counter.

Ports:
clk  input  1  core clock, rising edge.
reset_n  input  1  synchronous, active-low reset.
InstrF  input  32  instruction from fetch.
ValidF  input  1  InstrF holds a real instruction.
FlushD  input  1  branch/jump taken in EX; kill D and the EX-tracking slot.
StallF  output  1  hold PC/fetch; InstrF not accepted this cycle.
ValidD  output  1  decode slot holds a live instruction.
ImmFormatD  output  2  to extend unit: 00 I, 01 S, 10 B, 11 J.
ImmBitsD  output  25  instruction bits [31:7] to extend unit.
UsesImmD  output  1  ALU operand B comes from the immediate.
RegWriteD  output  1  instruction writes rd.
MemReadD  output  1  load.
MemWriteD  output  1  store.
Rs1D, Rs2D, RdD  output  5 each  register fields (zeroed when unused or invalid).
IllegalD  output  1  live instruction with unsupported opcode.
BubbleE  output  1  ID/EX register must load a NOP this cycle.
StallCntD  output  STALL_CNT_W  stall-cycle count (see Optional Feature).

Behaviour:
- Reset (reset_n=0 at an edge): InstrD=0, ValidD=0, FSM=RUN, EX-tracking cleared, StallCntD=0.
  - While invalid, all decode outputs are 0: ImmFormatD=00, ImmBitsD=0, flags 0, Rs/Rd 0, IllegalD=0, StallF=0, BubbleE=0.
  - Reset mid-stall abandons the stall; InstrF presented during reset is not captured.
- Decode is combinational from the registered InstrD; all flags are gated by ValidD.
  - 0010011 OP-IMM: I, UsesImm, RegWrite.
  - 0000011 LOAD: I, UsesImm, RegWrite, MemRead.
  - 1100111 JALR: I, UsesImm, RegWrite.
  - 0100011 STORE: S, UsesImm, MemWrite; rs2 used.
  - 1100011 BRANCH: B, rs2 used.
  - 1101111 JAL: J, RegWrite; rs1 unused.
  - 0110011 OP: format 00, UsesImm=0, RegWrite; rs2 used.
  - Any other opcode (incl. LUI/AUIPC): IllegalD=1, all other flags 0, format 00.
- ImmBitsD = InstrD[31:7] always when valid; the extend result therefore appears in the same cycle (zero latency).
- EX-tracking registers: ValidE_t, MemReadE_t, RdE_t. They capture the D-stage values each cycle unless BubbleE or FlushD, in which case they clear.
- Load-use hazard (combinational), all of:
  - ValidD, ValidE_t, MemReadE_t, RdE_t!=0;
  - and RdE_t==Rs1D (rs1 used) or RdE_t==Rs2D (rs2 used).
- FSM:
  - RUN: on hazard and !FlushD, assert StallF=1 and BubbleE=1, hold InstrD, go to STALL. Otherwise load InstrD/ValidD from InstrF/ValidF.
  - STALL: exactly one cycle; EX-tracking now holds the bubble, so the hazard is clear. Decode proceeds as in RUN, then return to RUN.
    - A new hazard against the bubble is impossible.
    - Back-to-back loads feeding each other stall once per pair.
- FlushD priority over stall:
  - ValidD<=0 next cycle; EX-tracking cleared; StallF=0 that cycle; FSM returns to RUN.
  - The instruction on InstrF is discarded (the fetch redirect supplies the next one).
- ValidF=0 while not stalled: D loads an invalid slot (pipeline bubble propagates).

Optional Feature:
Macro DECODE_STALL_CNT_EN.
- Defined: StallCntD increments by 1 on every cycle StallF=1 due to load-use, and saturates at all-ones. Flush and reset behave as specified above.
- Undefined: no counter logic; StallCntD is tied to 0.

Decomposition:
- Shared package skylark_pkg:
  - opcode localparams (OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_OP);
  - imm_format_t enum (IMM_I=2'b00, IMM_S, IMM_B, IMM_J), shared with the extend unit;
  - decode_state_t enum (RUN, STALL).
- One sub-module, opcode_decoder: purely combinational opcode to format/flags/rs-usage.

Test Plan:
- Reset with ValidF=1, InstrF=0x00500093 held -> ValidD=0, ImmFormatD=00, StallF=0. Once reset_n=1, next cycle ValidD=1, UsesImmD=1, RdD=1, ImmFormatD=00.
- Stream sw x2,8(x1) (0x0020A423) then beq x1,x2,+16 (0x00208863) then jal x1,+2048 (0x001000EF) -> ImmFormatD 01, 10, 11 on consecutive cycles; no stall.
- lw x5,0(x1) (0x0000A283) then add x6,x5,x7 (0x00728333) -> one cycle StallF=1, BubbleE=1; add held in D; then proceeds. StallCntD=1 with macro, 0 without.
- lw x0,0(x1) then add x6,x0,x7 -> no stall (rd=0). lw x5 then jal -> no stall (rs1 unused).
- Load-use stall cycle with FlushD=1 simultaneously -> no stall; ValidD=0 next cycle; BubbleE=0; FSM RUN.
- InstrF=0x00000037 (LUI) -> IllegalD=1, RegWriteD=0, UsesImmD=0. reset_n=0 during STALL -> next cycle all outputs 0, FSM RUN.

Source files
------------

// File: rtl/skylark_pkg.sv
// -----------------------------------------------------------------------------
// skylark_pkg
// Shared definitions for the RV32I decode stage: major opcode constants,
// the immediate-format select shared with the extend unit, the decode
// controller state type and the bundle of flags produced by opcode_decoder.
// No ports (package).
// -----------------------------------------------------------------------------
package skylark_pkg;

   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_format_t;

   typedef enum logic {
      RUN   = 1'b0,
      STALL = 1'b1
   } decode_state_t;

   // Register-field usage travels with the control flags so the hazard
   // check and the field zeroing both come from a single decode.
   typedef struct packed {
      imm_format_t immFormat;
      logic        usesImm;
      logic        regWrite;
      logic        memRead;
      logic        memWrite;
      logic        rs1Used;
      logic        rs2Used;
      logic        illegal;
   } dec_flags_t;

endpackage

// File: rtl/decode_ctrl_opcode_decoder.sv
// -----------------------------------------------------------------------------
// opcode_decoder
// Purely combinational map from the 7-bit major opcode to immediate format,
// control flags and source-register usage. Unknown opcodes (including
// LUI/AUIPC) raise only the illegal flag.
// Ports:
//   opcode_i  in   7   instruction bits [6:0]
//   flags_o   out  --  dec_flags_t bundle
// -----------------------------------------------------------------------------
module opcode_decoder
   import skylark_pkg::*;
(
   input  logic [6:0]  opcode_i,
   output dec_flags_t  flags_o
);

   // Every field defaults to zero / IMM_I so only set bits are listed below.
   always_comb begin
      flags_o           = '0;
      flags_o.immFormat = IMM_I;
      unique case (opcode_i)
         OPC_OP_IMM: begin
            flags_o.usesImm  = 1'b1;
            flags_o.regWrite = 1'b1;
            flags_o.rs1Used  = 1'b1;
         end
         OPC_LOAD: begin
            flags_o.usesImm  = 1'b1;
            flags_o.regWrite = 1'b1;
            flags_o.memRead  = 1'b1;
            flags_o.rs1Used  = 1'b1;
         end
         OPC_JALR: begin
            flags_o.usesImm  = 1'b1;
            flags_o.regWrite = 1'b1;
            flags_o.rs1Used  = 1'b1;
         end
         OPC_STORE: begin
            flags_o.immFormat = IMM_S;
            flags_o.usesImm   = 1'b1;
            flags_o.memWrite  = 1'b1;
            flags_o.rs1Used   = 1'b1;
            flags_o.rs2Used   = 1'b1;
         end
         OPC_BRANCH: begin
            flags_o.immFormat = IMM_B;
            flags_o.rs1Used   = 1'b1;
            flags_o.rs2Used   = 1'b1;
         end
         OPC_JAL: begin
            flags_o.immFormat = IMM_J;
            flags_o.regWrite  = 1'b1;
         end
         OPC_OP: begin
            flags_o.regWrite = 1'b1;
            flags_o.rs1Used  = 1'b1;
            flags_o.rs2Used  = 1'b1;
         end
         default: begin
            flags_o.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/decode_ctrl.sv
// -----------------------------------------------------------------------------
// decode_ctrl
// Decode-stage controller for the pipelined RV32I core. Holds the IF/ID
// instruction register, decodes it, drives the immediate extend unit and
// sequences the front end (one-cycle load-use stall with bubble, branch
// flush).
// Optional feature: define DECODE_STALL_CNT_EN to build a saturating
// load-use stall-cycle counter on StallCntD; otherwise StallCntD is 0.
// Ports:
//   clk, reset_n          clock (rising edge), synchronous active-low reset
//   InstrF, ValidF        instruction from fetch and its valid
//   FlushD                taken branch/jump in EX: kill D and EX tracking
//   StallF                hold fetch; InstrF not accepted this cycle
//   ValidD                decode slot live
//   ImmFormatD, ImmBitsD  extend-unit controls (format, instr[31:7])
//   UsesImmD, RegWriteD, MemReadD, MemWriteD, IllegalD   decode flags
//   Rs1D, Rs2D, RdD       register fields, zero when unused/invalid
//   BubbleE               ID/EX loads a NOP this cycle
//   StallCntD             load-use stall-cycle count
// -----------------------------------------------------------------------------
module decode_ctrl
   import skylark_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int STALL_CNT_W = 32
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [XLEN-1:0]        InstrF,
   input  logic                   ValidF,
   input  logic                   FlushD,
   output logic                   StallF,
   output logic                   ValidD,
   output logic [1:0]             ImmFormatD,
   output logic [24:0]            ImmBitsD,
   output logic                   UsesImmD,
   output logic                   RegWriteD,
   output logic                   MemReadD,
   output logic                   MemWriteD,
   output logic [4:0]             Rs1D,
   output logic [4:0]             Rs2D,
   output logic [4:0]             RdD,
   output logic                   IllegalD,
   output logic                   BubbleE,
   output logic [STALL_CNT_W-1:0] StallCntD
);

   logic [XLEN-1:0] instrD_q, instrD_d;
   logic            validD_q, validD_d;
   decode_state_t   state_q, state_d;
   logic            validE_q, validE_d;
   logic            memReadE_q, memReadE_d;
   logic [4:0]      rdE_q, rdE_d;

   dec_flags_t rawFlags;
   dec_flags_t liveFlags;
   logic       loadUse;
   logic       stallNow;

   opcode_decoder uDecoder (
      .opcode_i (instrD_q[6:0]),
      .flags_o  (rawFlags)
   );

   // An empty decode slot must look exactly like a NOP to everything downstream.
   always_comb begin
      liveFlags = '0;
      if (validD_q) begin
         liveFlags = rawFlags;
      end
   end

   assign ValidD     = validD_q;
   assign ImmFormatD = liveFlags.immFormat;
   assign ImmBitsD   = validD_q ? instrD_q[31:7] : '0;
   assign UsesImmD   = liveFlags.usesImm;
   assign RegWriteD  = liveFlags.regWrite;
   assign MemReadD   = liveFlags.memRead;
   assign MemWriteD  = liveFlags.memWrite;
   assign IllegalD   = liveFlags.illegal;
   assign Rs1D       = liveFlags.rs1Used  ? instrD_q[19:15] : '0;
   assign Rs2D       = liveFlags.rs2Used  ? instrD_q[24:20] : '0;
   assign RdD        = liveFlags.regWrite ? instrD_q[11:7]  : '0;

   // Unused source fields are already zeroed and RdE is non-zero, so a plain
   // equality against the zeroed fields only matches real register reads.
   assign loadUse = validD_q && validE_q && memReadE_q && (rdE_q != 5'd0) &&
                    ((rdE_q == Rs1D) || (rdE_q == Rs2D));

   // Next-state and front-end control. Flush wins over everything; a stall
   // is only taken from RUN because the bubble sitting in EX during STALL
   // cannot produce a new load-use hazard.
   always_comb begin
      state_d  = state_q;
      instrD_d = InstrF;
      validD_d = ValidF;
      stallNow = 1'b0;
      if (FlushD) begin
         instrD_d = '0;
         validD_d = 1'b0;
         state_d  = RUN;
      end else begin
         unique case (state_q)
            RUN: begin
               if (loadUse) begin
                  stallNow = 1'b1;
                  instrD_d = instrD_q;
                  validD_d = validD_q;
                  state_d  = STALL;
               end
            end
            STALL: begin
               state_d = RUN;
            end
            default: begin
               state_d = RUN;
            end
         endcase
      end
   end

   assign StallF  = stallNow;
   assign BubbleE = stallNow;

   // EX-side shadow of the instruction leaving decode; a bubble or flush
   // leaves nothing there to forward a load result from.
   always_comb begin
      validE_d   = validD_q;
      memReadE_d = MemReadD;
      rdE_d      = RdD;
      if (stallNow || FlushD) begin
         validE_d   = 1'b0;
         memReadE_d = 1'b0;
         rdE_d      = '0;
      end
   end

   // Pipeline registers; reset also abandons any stall in progress.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         instrD_q   <= '0;
         validD_q   <= 1'b0;
         state_q    <= RUN;
         validE_q   <= 1'b0;
         memReadE_q <= 1'b0;
         rdE_q      <= '0;
      end else begin
         instrD_q   <= instrD_d;
         validD_q   <= validD_d;
         state_q    <= state_d;
         validE_q   <= validE_d;
         memReadE_q <= memReadE_d;
         rdE_q      <= rdE_d;
      end
   end

`ifdef DECODE_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stallCnt_q, stallCnt_d;

   // Counts load-use stall cycles and sticks at all-ones instead of wrapping.
   always_comb begin
      stallCnt_d = stallCnt_q;
      if (stallNow && !(&stallCnt_q)) begin
         stallCnt_d = stallCnt_q + {{(STALL_CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Counter register, cleared with the rest of the stage.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stallCnt_q <= '0;
      end else begin
         stallCnt_q <= stallCnt_d;
      end
   end

   assign StallCntD = stallCnt_q;
`else
   assign StallCntD = '0;
`endif

endmodule
